pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It generates clock-enable and bubble-flush controls for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It detects load-use hazards and squashes wrong-path instructions on taken branches. It also sequences multi-cycle data-memory accesses through a req/ack handshake with a timeout.

Parameters:
MEM_TIMEOUT, 15, max MEM_WAIT cycles before fatal error (1..255)
TO_W, 8, width of wait counter
CNT_W, 32, width of stall performance counter (only with macro)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_rs1  in  5  rs1 of instruction in IF/ID
id_rs2  in  5  rs2 of instruction in IF/ID
id_uses_rs1  in  1  IF/ID instruction reads rs1
id_uses_rs2  in  1  IF/ID instruction reads rs2
ex_load  in  1  ID/EXE holds a load
ex_rd  in  5  destination reg of ID/EXE instruction
ex_branch_taken  in  1  branch/jump resolved taken in EXE
mem_access  in  1  EXE/MEM holds load or store
mem_ack  in  1  data memory completes access
dmem_req  out  1  data memory request
ce_pc, ce_if_id, ce_id_exe, ce_exe_mem, ce_mem_wb  out  1 each  register enables
flush_if_id, flush_id_exe  out  1 each  load NOP (0x00000013) and clear control bits at next edge
mem_err  out  1  sticky timeout error
stall_cycles  out  CNT_W  stall counter (macro only)

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. State register and wait counter are reset asynchronously to RUN / 0.
- While rst=1: all CE=0, flushes=0, dmem_req=0, mem_err=0.
- Outputs are combinational from state and inputs. State updates on posedge clk.
- Priority, highest first: ERR > memory stall > branch flush > load-use > normal.
- RUN, mem_access=1:
  - dmem_req=1.
  - If mem_ack=1 in the same cycle, the access takes zero wait: all CE=1.
  - Otherwise all CE=0, flushes=0, and the FSM goes to MEM_WAIT with counter=1.
- MEM_WAIT:
  - dmem_req=1, all CE=0, flushes=0.
  - mem_ack=1 → all CE=1 this cycle, next state RUN, counter=0.
  - Else if counter==MEM_TIMEOUT → next state ERR. Otherwise counter+1.
- ERR: all CE=0, dmem_req=0, mem_err=1. Only rst exits ERR.
- Branch (RUN, no memory stall, ex_branch_taken=1): all CE=1, flush_if_id=1, flush_id_exe=1.
- Load-use (RUN, no memory stall, no taken branch):
  - Condition: ex_load=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
  - Response: ce_pc=0, ce_if_id=0, flush_id_exe=1, ce_exe_mem=1, ce_mem_wb=1.
  - Exactly one bubble per hazard. The next cycle ID/EXE holds a NOP, so the condition clears.
- Normal: all CE=1, flushes=0.
- A branch arriving during a memory stall is held in the frozen ID/EXE. It is applied in the cycle the stall releases, which is the mem_ack cycle. The flush is not lost and is not applied twice.
- A flush asserted together with CE=0 on the same register: the flush is ignored. Flush is asserted only when CE=1.
- mem_ack while mem_access=0 is ignored.
- rst mid-MEM_WAIT: immediate return to RUN, dmem_req drops asynchronously.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: stall_cycles increments by 1 each posedge where rst=0 and ce_pc=0 (load-use, memory wait or ERR). It saturates at all-ones and resets to 0.
- Undefined: the port is absent and no counter logic is generated.

Test Plan:
- Normal flow: mem_access=0, no hazards for 10 cycles → all CE=1, flushes=0, dmem_req=0 every cycle.
- Load-use: ex_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle with ce_pc=ce_if_id=0 and flush_id_exe=1; ex_rd=0 with the same pattern → no stall.
- Memory wait: mem_access=1, mem_ack arrives on the 4th cycle → dmem_req=1 for 4 cycles, CE=0 for 3 cycles, CE=1 on the ack cycle; stall_cycles=3.
- Branch during stall: ex_branch_taken=1 with mem_access=1, ack after 2 cycles → flushes 0 while stalled; flush_if_id=flush_id_exe=1 only in the ack cycle.
- Timeout: mem_access=1, mem_ack=0 with MEM_TIMEOUT=15 → ERR entered after 15 wait cycles, mem_err=1 and all CE=0 held; asserting rst → RUN, mem_err=0.
- Async reset mid-wait: rst pulsed between clock edges in MEM_WAIT → dmem_req=0 and all CE=0 immediately; after release, state is RUN with counter=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Latency: all controls are combinational from FSM state and current inputs; state updates on posedge clk.
// Backpressure: a pending data-memory access freezes every pipeline register until mem_ack or timeout (ERR).
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   id_rs1/id_rs2/id_uses_*    source registers of the IF/ID instruction
//   ex_load, ex_rd             load flag and destination of the ID/EXE instruction
//   ex_branch_taken            branch/jump resolved taken in EXE
//   mem_access, mem_ack        EXE/MEM holds a load/store; data memory completion
//   dmem_req                   data memory request
//   ce_*                       clock enables for PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB
//   flush_if_id, flush_id_exe  load a NOP into the register at the next edge
//   mem_err                    sticky memory-timeout error (cleared only by rst)
//   stall_cycles               stall performance counter, present only with PIPE_PERF_CNT_EN
//
// Optional feature macro: PIPE_PERF_CNT_EN (adds the saturating stall_cycles counter).
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ack,
  output logic             dmem_req,
  output logic             ce_pc,
  output logic             ce_if_id,
  output logic             ce_id_exe,
  output logic             ce_exe_mem,
  output logic             ce_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  state_t          state;
  logic [TO_W-1:0] wait_cnt;

  logic ack_ok;
  logic load_use;
  logic resolve;

  // An ack only counts while a memory access is actually outstanding.
  assign ack_ok = mem_access & mem_ack;

  assign load_use = ex_load && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Control generation. 'resolve' marks a cycle in which the pipeline is not
  // held by memory, so branch / load-use / normal resolution applies. A branch
  // (or hazard) that sat in the frozen ID/EXE during a memory wait is therefore
  // handled exactly once, in the ack cycle that releases the stall.
  always_comb begin
    dmem_req     = 1'b0;
    ce_pc        = 1'b0;
    ce_if_id     = 1'b0;
    ce_id_exe    = 1'b0;
    ce_exe_mem   = 1'b0;
    ce_mem_wb    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    mem_err      = 1'b0;
    resolve      = 1'b0;

    if (!rst) begin
      case (state)
        RUN: begin
          dmem_req = mem_access;
          resolve  = !mem_access || ack_ok;
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          resolve  = ack_ok;
        end
        ERR: begin
          mem_err = 1'b1;
        end
        default: begin
          resolve = 1'b0;
        end
      endcase

      if (resolve) begin
        if (ex_branch_taken) begin
          ce_pc        = 1'b1;
          ce_if_id     = 1'b1;
          ce_id_exe    = 1'b1;
          ce_exe_mem   = 1'b1;
          ce_mem_wb    = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_exe = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, inject one bubble into ID/EXE. ID/EXE must be
          // enabled for its flush to take effect.
          ce_id_exe    = 1'b1;
          ce_exe_mem   = 1'b1;
          ce_mem_wb    = 1'b1;
          flush_id_exe = 1'b1;
        end else begin
          ce_pc        = 1'b1;
          ce_if_id     = 1'b1;
          ce_id_exe    = 1'b1;
          ce_exe_mem   = 1'b1;
          ce_mem_wb    = 1'b1;
        end
      end
    end
  end

  // State machine and wait counter. Counter holds the number of the current
  // MEM_WAIT cycle (1-based); reaching MEM_TIMEOUT without ack is fatal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_access && !mem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= TO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (ack_ok) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TO_LIM) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Counts every cycle the front end is held (load-use, memory wait, ERR);
  // saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!ce_pc && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes the expected control vector for every
// cycle it drives; an independent monitor pops and compares on the negedge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       ex_load = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_access = 1'b0, mem_ack = 1'b0;
  logic       dmem_req, ce_pc, ce_if_id, ce_id_exe, ce_exe_mem, ce_mem_wb;
  logic       flush_if_id, flush_id_exe, mem_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_load(ex_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ack(mem_ack),
    .dmem_req(dmem_req), .ce_pc(ce_pc), .ce_if_id(ce_if_id),
    .ce_id_exe(ce_id_exe), .ce_exe_mem(ce_exe_mem), .ce_mem_wb(ce_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe), .mem_err(mem_err)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // {dmem_req, ce_pc, ce_if_id, ce_id_exe, ce_exe_mem, ce_mem_wb, flush_if_id, flush_id_exe, mem_err}
  logic [8:0] obs;
  assign obs = {dmem_req, ce_pc, ce_if_id, ce_id_exe, ce_exe_mem, ce_mem_wb,
                flush_if_id, flush_id_exe, mem_err};

  localparam logic [8:0] ZERO     = 9'b0_00000_00_0;
  localparam logic [8:0] NORMAL   = 9'b0_11111_00_0;
  localparam logic [8:0] BRANCH   = 9'b0_11111_11_0;
  localparam logic [8:0] LOADUSE  = 9'b0_00111_01_0;
  localparam logic [8:0] MEMSTALL = 9'b1_00000_00_0;
  localparam logic [8:0] ACK      = 9'b1_11111_00_0;
  localparam logic [8:0] ACK_BR   = 9'b1_11111_11_0;
  localparam logic [8:0] ERRV     = 9'b0_00000_00_1;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [8:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic set_in(input logic ma, input logic ack, input logic br,
                        input logic ld, input logic [4:0] rd,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    mem_access = ma; mem_ack = ack; ex_branch_taken = br;
    ex_load = ld; ex_rd = rd;
    id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
  endtask

  // Monitor: one comparison per cycle for which the stimulus queued an expectation.
  initial begin
    logic [8:0] e;
    string      n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL %s: got %b expected %b (dmem,ce_pc..ce_mem_wb,fl_ifid,fl_idexe,err)",
                   n, obs, e);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(); expect_out(ZERO, "reset");
    tick(); rst = 1'b0; set_in(0,0,0,0,0,0,0,0,0); expect_out(NORMAL, "post_reset");

    // Normal flow, 10 cycles with varying unrelated register fields
    for (int i = 0; i < 10; i++) begin
      tick();
      set_in(0, 0, 0, 0, 5'(i), 5'(i + 1), 1'b1, 5'(i + 2), 1'b1);
      expect_out(NORMAL, "normal");
    end

    // Memory wait: ack on the 4th cycle
    tick(); set_in(1,0,0,0,0,0,0,0,0); expect_out(MEMSTALL, "mw_c1");
    tick(); expect_out(MEMSTALL, "mw_c2");
    tick(); expect_out(MEMSTALL, "mw_c3");
    tick(); mem_ack = 1'b1; expect_out(ACK, "mw_ack");
    tick(); set_in(0,0,0,0,0,0,0,0,0); expect_out(NORMAL, "mw_after");
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 3", stall_cycles);
    end
`endif

    // Load-use via rs2, then bubble clears it
    tick(); set_in(0,0,0,1,5'd5,5'd1,1'b0,5'd5,1'b1); expect_out(LOADUSE, "lu_rs2");
    tick(); set_in(0,0,0,0,5'd0,5'd1,1'b0,5'd5,1'b1); expect_out(NORMAL, "lu_bubble");
    // Same pattern with x0 destination: no hazard
    tick(); set_in(0,0,0,1,5'd0,5'd1,1'b0,5'd0,1'b1); expect_out(NORMAL, "lu_x0");
    // Load-use via rs1; then rs1 not used
    tick(); set_in(0,0,0,1,5'd7,5'd7,1'b1,5'd3,1'b0); expect_out(LOADUSE, "lu_rs1");
    tick(); set_in(0,0,0,1,5'd7,5'd7,1'b0,5'd3,1'b1); expect_out(NORMAL, "lu_unused");
    // Branch beats load-use
    tick(); set_in(0,0,1,1,5'd7,5'd7,1'b1,5'd3,1'b0); expect_out(BRANCH, "br_over_lu");
    tick(); set_in(0,0,1,0,0,0,0,0,0); expect_out(BRANCH, "branch");
    // Zero-wait access, and stray ack without access
    tick(); set_in(1,1,0,0,0,0,0,0,0); expect_out(ACK, "zero_wait");
    tick(); set_in(0,1,0,0,0,0,0,0,0); expect_out(NORMAL, "stray_ack");

    // Branch during memory stall: flushes only in the ack cycle
    tick(); set_in(1,0,1,0,0,0,0,0,0); expect_out(MEMSTALL, "brs_c1");
    tick(); expect_out(MEMSTALL, "brs_c2");
    tick(); mem_ack = 1'b1; expect_out(ACK_BR, "brs_ack");
    tick(); set_in(0,0,0,0,0,0,0,0,0); expect_out(NORMAL, "brs_after");

    // Timeout: 1 RUN stall cycle + 15 MEM_WAIT cycles, then ERR
    tick(); set_in(1,0,0,0,0,0,0,0,0); expect_out(MEMSTALL, "to_run");
    for (int i = 1; i <= 15; i++) begin
      tick(); expect_out(MEMSTALL, "to_wait");
    end
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out(ERRV, "to_err");
    end
    tick(); mem_ack = 1'b1; expect_out(ERRV, "err_ignores_ack");
    tick(); rst = 1'b1; set_in(0,0,0,0,0,0,0,0,0); expect_out(ZERO, "err_rst");
    tick(); rst = 1'b0; expect_out(NORMAL, "err_cleared");

    // Asynchronous reset pulse in the middle of MEM_WAIT
    tick(); set_in(1,0,0,0,0,0,0,0,0); expect_out(MEMSTALL, "ar_c1");
    tick(); expect_out(MEMSTALL, "ar_c2");
    tick(); rst = 1'b1; expect_out(ZERO, "ar_pulse");
    @(negedge clk); #1; rst = 1'b0; mem_access = 1'b0;
    tick(); expect_out(NORMAL, "ar_run");
    tick(); mem_access = 1'b1; expect_out(MEMSTALL, "ar_new_c1");
    tick(); mem_ack = 1'b1; expect_out(ACK, "ar_new_ack");
    tick(); set_in(0,0,0,0,0,0,0,0,0); expect_out(NORMAL, "ar_end");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
